// File: rtl/bp_table_arbiter_if.sv
// Request/response and table-port bundle for bp_table_arbiter.
// slave is the arbiter side; master is the fetch/resolution/table side.
interface bp_table_arbiter_if #(parameter int IDX_W = 7);
  logic             lkp_valid;
  logic [IDX_W-1:0] lkp_idx;
  logic             lkp_ready;
  logic             lkp_rsp_valid;
  logic [1:0]       lkp_rsp_ctr;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             upd_ready;
  logic             flush_req;
  logic             busy;
  logic             tbl_en;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_addr;
  logic [1:0]       tbl_wdata;
  logic [1:0]       tbl_rdata;
  logic [31:0]      upd_count;
  logic [31:0]      flip_count;

  modport slave (
    input  lkp_valid, lkp_idx, upd_valid, upd_idx, upd_taken, flush_req, tbl_rdata,
    output lkp_ready, lkp_rsp_valid, lkp_rsp_ctr, upd_ready, busy,
           tbl_en, tbl_we, tbl_addr, tbl_wdata, upd_count, flip_count
  );

  modport master (
    output lkp_valid, lkp_idx, upd_valid, upd_idx, upd_taken, flush_req, tbl_rdata,
    input  lkp_ready, lkp_rsp_valid, lkp_rsp_ctr, upd_ready, busy,
           tbl_en, tbl_we, tbl_addr, tbl_wdata, upd_count, flip_count
  );
endinterface

// File: rtl/bp_table_arbiter.sv
// Shares one single-port 2-bit PHT between fetch lookups and queued saturating updates,
// and walks the table to INIT_CTR after reset/flush. Define BP_ARB_STATS_EN for update stats.
module bp_table_arbiter #(
  parameter int         IDX_W    = 7,
  parameter int         UQ_DEPTH = 4,
  parameter logic [1:0] INIT_CTR = 2'b01
) (
  input logic               clk,
  input logic               reset,
  bp_table_arbiter_if.slave bus
);
  localparam int PW = $clog2(UQ_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_UPD_WR} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] uq_idx_q [UQ_DEPTH];
  logic [IDX_W-1:0] uq_idx_d [UQ_DEPTH];
  logic [UQ_DEPTH-1:0] uq_tkn_q, uq_tkn_d;
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rsp_vld_q, rsp_vld_d;

  logic             full, empty, push, pop, clr, lkp_go;
  logic [IDX_W-1:0] head_idx;
  logic             head_tkn;
  logic [1:0]       new_ctr;

  always_comb begin
    full     = (cnt_q == CW'(UQ_DEPTH));
    empty    = (cnt_q == '0);
    head_idx = uq_idx_q[rd_q];
    head_tkn = uq_tkn_q[rd_q];
    if (head_tkn) new_ctr = (bus.tbl_rdata == 2'b11) ? 2'b11 : bus.tbl_rdata + 2'b01;
    else          new_ctr = (bus.tbl_rdata == 2'b00) ? 2'b00 : bus.tbl_rdata - 2'b01;
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    pop           = 1'b0;
    clr           = 1'b0;
    lkp_go        = 1'b0;
    bus.tbl_en    = 1'b0;
    bus.tbl_we    = 1'b0;
    bus.tbl_addr  = '0;
    bus.tbl_wdata = 2'b00;
    bus.lkp_ready = 1'b0;
    bus.upd_ready = 1'b0;
    if (!reset) begin
      case (state_q)
        S_INIT: begin
          bus.tbl_en    = 1'b1;
          bus.tbl_we    = 1'b1;
          bus.tbl_addr  = ptr_q;
          bus.tbl_wdata = INIT_CTR;
          ptr_d         = ptr_q + 1'b1;  // wraps to 0, ready for the next walk
          if (ptr_q == '1) state_d = S_IDLE;
        end
        S_IDLE: begin
          bus.lkp_ready = !full;
          bus.upd_ready = !full;
          // A full queue hands the port to updates so it always drains.
          if (bus.lkp_valid && !full) begin
            lkp_go       = 1'b1;
            bus.tbl_en   = 1'b1;
            bus.tbl_addr = bus.lkp_idx;
          end else if (!empty && !bus.flush_req) begin
            bus.tbl_en   = 1'b1;
            bus.tbl_addr = head_idx;
            state_d      = S_UPD_WR;
          end
          if (bus.flush_req) begin
            clr     = 1'b1;
            state_d = S_INIT;
          end
        end
        S_UPD_WR: begin
          bus.upd_ready = !full;
          bus.tbl_en    = 1'b1;
          bus.tbl_we    = 1'b1;
          bus.tbl_addr  = head_idx;
          bus.tbl_wdata = new_ctr;
          pop           = 1'b1;
          clr           = bus.flush_req;
          state_d       = bus.flush_req ? S_INIT : S_IDLE;
        end
        default: state_d = S_INIT;
      endcase
    end
  end

  assign push = bus.upd_valid & bus.upd_ready;

  always_comb begin
    uq_idx_d = uq_idx_q;
    uq_tkn_d = uq_tkn_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    if (push) begin
      uq_idx_d[wr_q] = bus.upd_idx;
      uq_tkn_d[wr_q] = bus.upd_taken;
      wr_d           = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  assign rsp_vld_d = lkp_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_INIT;
      ptr_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      rsp_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      rsp_vld_q <= rsp_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    uq_idx_q <= uq_idx_d;
    uq_tkn_q <= uq_tkn_d;
  end

  assign bus.lkp_rsp_valid = rsp_vld_q;
  assign bus.lkp_rsp_ctr   = rsp_vld_q ? bus.tbl_rdata : 2'b00;
  assign bus.busy          = reset | (state_q == S_INIT);

`ifdef BP_ARB_STATS_EN
  logic [31:0] upd_count_q, upd_count_d, flip_count_q, flip_count_d;

  always_comb begin
    upd_count_d  = upd_count_q;
    flip_count_d = flip_count_q;
    if (pop) begin
      upd_count_d = upd_count_q + 32'd1;
      if (bus.tbl_rdata[1] != new_ctr[1]) flip_count_d = flip_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upd_count_q  <= '0;
      flip_count_q <= '0;
    end else begin
      upd_count_q  <= upd_count_d;
      flip_count_q <= flip_count_d;
    end
  end

  assign bus.upd_count  = upd_count_q;
  assign bus.flip_count = flip_count_q;
`else
  assign bus.upd_count  = 32'd0;
  assign bus.flip_count = 32'd0;
`endif
endmodule

// File: tb/tb_bp_table_arbiter.sv
// Directed bench for bp_table_arbiter with IDX_W=3 and a behavioural single-port PHT.
module tb_bp_table_arbiter;
  localparam int IDX_W = 3;
  localparam int N     = 1 << IDX_W;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  bp_table_arbiter_if #(.IDX_W(IDX_W)) bus();

  bp_table_arbiter #(.IDX_W(IDX_W), .UQ_DEPTH(4), .INIT_CTR(2'b01)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Single-port table: read data appears the cycle after a read
  logic [1:0] mem [N];
  always @(posedge clk) begin
    if (bus.tbl_en) begin
      if (bus.tbl_we) mem[bus.tbl_addr] <= bus.tbl_wdata;
      else            bus.tbl_rdata     <= mem[bus.tbl_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic lookup(input logic [IDX_W-1:0] idx, input logic [1:0] exp, input string tag);
    int n = 0;
    bus.lkp_valid = 1'b1;
    bus.lkp_idx   = idx;
    #1;
    while (!bus.lkp_ready && n < 20) begin step(); n++; end
    if (n >= 20) chk({tag, "_ready_timeout"}, 32'(n), 32'd0);
    step();
    bus.lkp_valid = 1'b0;
    chk({tag, "_rsp_valid"}, 32'(bus.lkp_rsp_valid), 32'd1);
    chk({tag, "_rsp_ctr"},   32'(bus.lkp_rsp_ctr),   32'(exp));
  endtask

  task automatic push(input logic [IDX_W-1:0] idx, input logic taken);
    int n = 0;
    bus.upd_valid = 1'b1;
    bus.upd_idx   = idx;
    bus.upd_taken = taken;
    #1;
    while (!bus.upd_ready && n < 20) begin step(); n++; end
    if (n >= 20) chk("push_ready_timeout", 32'(n), 32'd0);
    step();
    bus.upd_valid = 1'b0;
  endtask

  task automatic chk_stats(input int upd, input int flip, input string tag);
`ifdef BP_ARB_STATS_EN
    chk({tag, "_upd_count"},  bus.upd_count,  32'(upd));
    chk({tag, "_flip_count"}, bus.flip_count, 32'(flip));
`else
    chk({tag, "_upd_count"},  bus.upd_count,  32'd0);
    chk({tag, "_flip_count"}, bus.flip_count, 32'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    reset         = 1'b1;
    bus.lkp_valid = 1'b0;
    bus.lkp_idx   = '0;
    bus.upd_valid = 1'b0;
    bus.upd_idx   = '0;
    bus.upd_taken = 1'b0;
    bus.flush_req = 1'b0;
    idle(3);

    chk("rst_busy",      32'(bus.busy),          32'd1);
    chk("rst_lkp_ready", 32'(bus.lkp_ready),     32'd0);
    chk("rst_upd_ready", 32'(bus.upd_ready),     32'd0);
    chk("rst_tbl_en",    32'(bus.tbl_en),        32'd0);
    chk("rst_tbl_we",    32'(bus.tbl_we),        32'd0);
    chk("rst_rsp_valid", 32'(bus.lkp_rsp_valid), 32'd0);
    chk("rst_rsp_ctr",   32'(bus.lkp_rsp_ctr),   32'd0);
    chk_stats(0, 0, "rst");

    // Init walk: 8 writes of 01 to addresses 0..7, then IDLE on cycle 9
    reset = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("init_we_%0d", i),    32'(bus.tbl_we),    32'd1);
      chk($sformatf("init_addr_%0d", i),  32'(bus.tbl_addr),  32'(i));
      chk($sformatf("init_wdata_%0d", i), 32'(bus.tbl_wdata), 32'd1);
      chk($sformatf("init_busy_%0d", i),  32'(bus.busy),      32'd1);
      step();
    end
    chk("init_done_busy",  32'(bus.busy),      32'd0);
    chk("init_done_ready", 32'(bus.lkp_ready), 32'd1);
    chk("init_done_uready",32'(bus.upd_ready), 32'd1);

    // First lookup: port read of index 5, response next cycle
    bus.lkp_valid = 1'b1;
    bus.lkp_idx   = 3'd5;
    #1;
    chk("lkp5_tbl_en",   32'(bus.tbl_en),   32'd1);
    chk("lkp5_tbl_we",   32'(bus.tbl_we),   32'd0);
    chk("lkp5_tbl_addr", 32'(bus.tbl_addr), 32'd5);
    step();
    bus.lkp_valid = 1'b0;
    chk("lkp5_rsp_valid", 32'(bus.lkp_rsp_valid), 32'd1);
    chk("lkp5_rsp_ctr",   32'(bus.lkp_rsp_ctr),   32'd1);
    step();
    chk("lkp5_rsp_gone",  32'(bus.lkp_rsp_valid), 32'd0);

    // Saturation: 01 -> 10 -> 11 -> 11, then 11 x2, then down to 00
    repeat (3) push(3'd2, 1'b1);
    idle(10);
    lookup(3'd2, 2'b11, "sat_up3");
    repeat (2) push(3'd2, 1'b1);
    idle(8);
    lookup(3'd2, 2'b11, "sat_up5");
    repeat (4) push(3'd2, 1'b0);
    idle(12);
    lookup(3'd2, 2'b00, "sat_dn4");
    chk_stats(9, 2, "sat");

    // Continuous lookups fill the queue; a full queue forces one update RMW
    bus.lkp_valid = 1'b1;
    bus.lkp_idx   = 3'd0;
    bus.upd_valid = 1'b1;
    bus.upd_idx   = 3'd3;
    bus.upd_taken = 1'b1;
    idle(4);
    bus.upd_valid = 1'b0;
    #1;
    chk("full_lkp_ready", 32'(bus.lkp_ready), 32'd0);
    chk("full_upd_ready", 32'(bus.upd_ready), 32'd0);
    chk("full_rd_we",     32'(bus.tbl_we),    32'd0);
    chk("full_rd_addr",   32'(bus.tbl_addr),  32'd3);
    step();
    chk("full_wr_we",     32'(bus.tbl_we),    32'd1);
    chk("full_wr_addr",   32'(bus.tbl_addr),  32'd3);
    chk("full_wr_data",   32'(bus.tbl_wdata), 32'd2);
    chk("full_wr_lready", 32'(bus.lkp_ready), 32'd0);
    step();
    chk("full_back_ready",32'(bus.lkp_ready), 32'd1);
    chk("full_back_addr", 32'(bus.tbl_addr),  32'd0);
    chk("full_back_we",   32'(bus.tbl_we),    32'd0);
    bus.lkp_valid = 1'b0;
    idle(10);
    lookup(3'd3, 2'b11, "full_drain");
    chk_stats(13, 3, "full");

    // Flush during UPD_WR with 3 queued: head write lands, rest discarded
    bus.lkp_valid = 1'b1;
    bus.lkp_idx   = 3'd0;
    push(3'd6, 1'b1);
    push(3'd7, 1'b1);
    push(3'd6, 1'b1);
    bus.lkp_valid = 1'b0;
    step();
    bus.flush_req = 1'b1;
    #1;
    chk("flush_wr_we",   32'(bus.tbl_we),    32'd1);
    chk("flush_wr_addr", 32'(bus.tbl_addr),  32'd6);
    chk("flush_wr_data", 32'(bus.tbl_wdata), 32'd2);
    step();
    bus.flush_req = 1'b0;
    n = 0;
    while (bus.busy && n < 20) begin n++; step(); end
    chk("flush_busy_cycles", 32'(n), 32'(N));
    for (int i = 0; i < N; i++) lookup(3'(i), 2'b01, $sformatf("flush_rd_%0d", i));
    chk_stats(14, 4, "flush");

    // Push and pop in the same cycle at occupancy 3 keeps occupancy 3
    bus.lkp_valid = 1'b1;
    bus.lkp_idx   = 3'd0;
    bus.upd_valid = 1'b1;
    bus.upd_idx   = 3'd1;
    bus.upd_taken = 1'b1;
    idle(3);
    bus.upd_valid = 1'b0;
    bus.lkp_valid = 1'b0;
    step();
    bus.upd_valid = 1'b1;
    #1;
    chk("pp_wr_we",    32'(bus.tbl_we),    32'd1);
    chk("pp_upd_ready",32'(bus.upd_ready), 32'd1);
    step();
    bus.lkp_valid = 1'b1;
    #1;
    chk("pp_after_lready", 32'(bus.lkp_ready), 32'd1);
    chk("pp_after_uready", 32'(bus.upd_ready), 32'd1);
    step();
    bus.upd_valid = 1'b0;
    #1;
    chk("pp_full_lready", 32'(bus.lkp_ready), 32'd0);
    chk("pp_full_uready", 32'(bus.upd_ready), 32'd0);
    bus.lkp_valid = 1'b0;
    idle(14);
    lookup(3'd1, 2'b11, "pp_drain");
    chk_stats(19, 5, "pp");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
